// File: rtl/pe_tile_sequencer.sv
// Tile sequencer for a ws_os_pe (or a row sharing broadcast controls): clear, stream K beats, drain, return result.
// Optional PE_SEQ_PERF_EN adds tile and stall counters.
module pe_tile_sequencer #(
  parameter int DW     = 16,
  parameter int KW     = 8,
  parameter int PE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_mode_i,
  input  logic [KW-1:0]   cmd_k_i,
  input  logic [DW-1:0]   cmd_w_i,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [DW-1:0]   op_a_i,
  input  logic [DW-1:0]   op_b_i,
  output logic            pe_mode_o,
  output logic            pe_load_w_o,
  output logic [DW-1:0]   pe_w_o,
  output logic            pe_clr_o,
  output logic            pe_valid_o,
  output logic [DW-1:0]   pe_a_o,
  output logic [DW-1:0]   pe_b_o,
  input  logic [2*DW-1:0] pe_accum_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [2*DW-1:0] res_data_o,
  output logic            busy_o
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_tiles_o,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;
  localparam int DCW = $clog2(PE_LAT + 2);

  logic [2:0]      state_q, state_d;
  logic            mode_q, mode_d;
  logic [KW-1:0]   k_q, k_d, cnt_q, cnt_d;
  logic [DW-1:0]   ad_q, ad_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;
  logic            cmd_ready_q, cmd_ready_d, op_ready_q, op_ready_d, busy_q, busy_d;
  logic            pe_mode_q, pe_mode_d, pe_load_w_q, pe_load_w_d, pe_clr_q, pe_clr_d;
  logic            pe_valid_q, pe_valid_d, res_valid_q, res_valid_d;
  logic [DW-1:0]   pe_w_q, pe_w_d, pe_a_q, pe_a_d, pe_b_q, pe_b_d;
  logic [2*DW-1:0] res_data_q, res_data_d;
  logic            cmd_hs, op_hs, res_hs;

  assign cmd_hs = cmd_valid_i & cmd_ready_q;
  assign op_hs  = op_valid_i & op_ready_q;
  assign res_hs = res_valid_q & res_ready_i;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    ad_d        = ad_q;
    dcnt_d      = dcnt_q;
    op_ready_d  = 1'b0;
    pe_mode_d   = pe_mode_q;
    pe_w_d      = pe_w_q;
    pe_load_w_d = 1'b0;
    pe_clr_d    = 1'b0;
    pe_valid_d  = 1'b0;
    pe_a_d      = '0;
    pe_b_d      = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      S_IDLE: if (cmd_hs) begin
        mode_d    = cmd_mode_i;
        k_d       = cmd_k_i;
        cnt_d     = '0;
        ad_d      = '0;
        pe_mode_d = cmd_mode_i;
        pe_clr_d  = 1'b1;
        if (!cmd_mode_i) begin
          pe_load_w_d = 1'b1;
          pe_w_d      = cmd_w_i;
        end
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (k_q == '0) begin
          res_valid_d = 1'b1;
          res_data_d  = '0;
          state_d     = S_RESULT;
        end else begin
          op_ready_d = 1'b1;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        op_ready_d = 1'b1;
        if (op_hs) begin
          cnt_d      = cnt_q + KW'(1);
          pe_valid_d = 1'b1;
          // OS feeds the previous a so it pairs with the b the PE registered last beat
          pe_a_d     = mode_q ? ad_q : op_a_i;
          pe_b_d     = mode_q ? op_b_i : '0;
          ad_d       = op_a_i;
          if (cnt_d == k_q) begin
            op_ready_d = 1'b0;
            dcnt_d     = '0;
            state_d    = mode_q ? S_FLUSH : S_DRAIN;
          end
        end
      end
      S_FLUSH: begin
        pe_valid_d = 1'b1;
        pe_a_d     = ad_q;
        dcnt_d     = '0;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        if (dcnt_q == DCW'(PE_LAT)) begin
          res_valid_d = 1'b1;
          res_data_d  = pe_accum_i;
          state_d     = S_RESULT;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      S_RESULT: if (res_hs) begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      k_q         <= '0;
      cnt_q       <= '0;
      ad_q        <= '0;
      dcnt_q      <= '0;
      cmd_ready_q <= 1'b0;
      op_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      pe_mode_q   <= 1'b0;
      pe_load_w_q <= 1'b0;
      pe_w_q      <= '0;
      pe_clr_q    <= 1'b0;
      pe_valid_q  <= 1'b0;
      pe_a_q      <= '0;
      pe_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      ad_q        <= ad_d;
      dcnt_q      <= dcnt_d;
      cmd_ready_q <= cmd_ready_d;
      op_ready_q  <= op_ready_d;
      busy_q      <= busy_d;
      pe_mode_q   <= pe_mode_d;
      pe_load_w_q <= pe_load_w_d;
      pe_w_q      <= pe_w_d;
      pe_clr_q    <= pe_clr_d;
      pe_valid_q  <= pe_valid_d;
      pe_a_q      <= pe_a_d;
      pe_b_q      <= pe_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign op_ready_o  = op_ready_q;
  assign busy_o      = busy_q;
  assign pe_mode_o   = pe_mode_q;
  assign pe_load_w_o = pe_load_w_q;
  assign pe_w_o      = pe_w_q;
  assign pe_clr_o    = pe_clr_q;
  assign pe_valid_o  = pe_valid_q;
  assign pe_a_o      = pe_a_q;
  assign pe_b_o      = pe_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

`ifdef PE_SEQ_PERF_EN
  logic [31:0] tiles_q, stall_q;
  logic        stall;
  assign stall = ((state_q == S_STREAM) & op_ready_q & ~op_valid_i) |
                 ((state_q == S_RESULT) & ~res_ready_i);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tiles_q <= '0;
      stall_q <= '0;
    end else begin
      tiles_q <= tiles_q + {31'd0, res_hs};
      stall_q <= stall_q + {31'd0, stall};
    end
  end
  assign perf_tiles_o = tiles_q;
  assign perf_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Randomized bench for pe_tile_sequencer: a behavioural PE drives pe_accum, and a tile-level model
// predicts the result, the PE beat sequence, pulse counts and latency.
module tb_pe_tile_sequencer;
  localparam int DW = 16;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cmd_valid, cmd_ready, cmd_mode;
  logic [KW-1:0] cmd_k;
  logic [DW-1:0] cmd_w;
  logic op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic pe_mode, pe_load_w, pe_clr, pe_valid;
  logic [DW-1:0] pe_w, pe_a, pe_b;
  logic [2*DW-1:0] pe_accum;
  logic res_valid, res_ready, busy;
  logic [2*DW-1:0] res_data;
`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_tiles, perf_stall;
`endif

  pe_tile_sequencer #(.DW(DW), .KW(KW), .PE_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_mode_i(cmd_mode),
    .cmd_k_i(cmd_k), .cmd_w_i(cmd_w),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_a_i(op_a), .op_b_i(op_b),
    .pe_mode_o(pe_mode), .pe_load_w_o(pe_load_w), .pe_w_o(pe_w), .pe_clr_o(pe_clr),
    .pe_valid_o(pe_valid), .pe_a_o(pe_a), .pe_b_o(pe_b), .pe_accum_i(pe_accum),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .busy_o(busy)
`ifdef PE_SEQ_PERF_EN
    , .perf_tiles_o(perf_tiles), .perf_stall_o(perf_stall)
`endif
  );

  // Behavioural PE, one-cycle MAC; OS multiplies by the b of the previous beat
  logic [2*DW-1:0] pm_acc = '0;
  logic [DW-1:0]   pm_w = '0, pm_bp = '0;
  always @(posedge clk) begin
    if (pe_load_w) pm_w <= pe_w;
    if (pe_clr) begin
      pm_acc <= '0;
      pm_bp  <= '0;
    end else if (pe_valid) begin
      pm_acc <= pm_acc + (pe_mode ? 32'(pe_a) * 32'(pm_bp) : 32'(pe_a) * 32'(pm_w));
      pm_bp  <= pe_b;
    end
  end
  assign pe_accum = pm_acc;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [DW-1:0] a; logic [DW-1:0] b; } beat_t;
  beat_t       exp_beats[$];
  logic [DW-1:0] opa[256];
  logic [DW-1:0] opb[256];
  logic [31:0] exp_res;
  logic        cur_mode;
  logic [DW-1:0] cur_w;
  bit          mon_en;
  int          total = 0, bad = 0;
  int          clr_tot = 0, ldw_tot = 0, vld_tot = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_tile(input logic mode, input int k, input logic [DW-1:0] w, input int gap,
                          input int hold, output logic [31:0] got, output int lat);
    int c0, idx, guard, s_clr, s_ldw, s_vld;
    bit hs;
    beat_t t;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < k; i++)
      r += mode ? 32'(opa[i]) * 32'(opb[i]) : 32'(w) * 32'(opa[i]);
    exp_beats.delete();
    if (!mode) begin
      for (int i = 0; i < k; i++) begin t.a = opa[i]; t.b = '0; exp_beats.push_back(t); end
    end else if (k > 0) begin
      t.a = '0; t.b = opb[0]; exp_beats.push_back(t);
      for (int i = 1; i < k; i++) begin t.a = opa[i-1]; t.b = opb[i]; exp_beats.push_back(t); end
      t.a = opa[k-1]; t.b = '0; exp_beats.push_back(t);
    end
    cur_mode = mode; cur_w = w; exp_res = r;
    s_clr = clr_tot; s_ldw = ldw_tot; s_vld = vld_tot;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_mode = mode; cmd_k = KW'(k); cmd_w = w; c0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_mode = 1'($urandom); cmd_k = KW'($urandom); cmd_w = DW'($urandom);
    chk("busy_after_accept", 64'(busy), 64'(1));
    idx = 0; guard = 0;
    while (idx < k && guard < 4000) begin
      op_valid = (gap == 0) ? 1'b1 : (gap == 1) ? guard[0] : ($urandom_range(0, 99) < 60);
      op_a = opa[idx]; op_b = opb[idx];
      hs = op_valid && op_ready;
      @(negedge clk);
      if (hs) idx++;
      guard++;
    end
    op_valid = 1'b0; op_a = DW'($urandom); op_b = DW'($urandom);
    chk("beats_accepted", 64'(idx), 64'(k));
    guard = 0;
    while (!res_valid && guard < 100) begin @(negedge clk); guard++; end
    chk("res_valid_seen", 64'(res_valid), 64'(1));
    lat = cyc - c0;
    if (gap == 0) chk("latency", 64'(lat), 64'(k == 0 ? 2 : (mode ? k + 5 : k + 4)));
    got = res_data;
    chk("result", 64'(res_data), 64'(r));
    cmd_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'(1));
      chk("hold_data", 64'(res_data), 64'(r));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_dropped", 64'(res_valid), 64'(0));
    chk("idle_ready", 64'(cmd_ready), 64'(1));
    chk("clr_pulses", 64'(clr_tot - s_clr), 64'(1));
    chk("ldw_pulses", 64'(ldw_tot - s_ldw), 64'(mode ? 0 : 1));
    chk("valid_pulses", 64'(vld_tot - s_vld), 64'(k == 0 ? 0 : (mode ? k + 1 : k)));
    chk("beats_left", 64'(exp_beats.size()), 64'(0));
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int lat;
    cmd_valid = 0; cmd_mode = 0; cmd_k = '0; cmd_w = '0;
    op_valid = 0; op_a = '0; op_b = '0; res_ready = 0;
    mon_en = 0; cur_mode = 0; cur_w = '0; exp_res = '0;
    fork
      forever begin
        beat_t b;
        @(negedge clk);
        if (mon_en) begin
          if (!pe_valid) chk("pe_ab_idle", 64'({pe_a, pe_b}), 64'(0));
          else begin
            vld_tot++;
            if (exp_beats.size() == 0) chk("pe_beat_extra", 64'(1), 64'(0));
            else begin
              b = exp_beats.pop_front();
              chk("pe_beat", 64'({pe_a, pe_b}), 64'({b.a, b.b}));
            end
          end
          if (pe_clr) clr_tot++;
          if (pe_load_w) begin
            ldw_tot++;
            chk("pe_w", 64'(pe_w), 64'(cur_w));
          end
          chk("busy_vs_ready", 64'(busy), 64'(!cmd_ready));
          if (busy) chk("pe_mode", 64'(pe_mode), 64'(cur_mode));
          if (res_valid) chk("res_data", 64'(res_data), 64'(exp_res));
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_op_ready", 64'(op_ready), 64'(0));
    chk("rst_pe", 64'({pe_mode, pe_load_w, pe_clr, pe_valid, pe_w, pe_a, pe_b}), 64'(0));
    chk("rst_res", 64'({res_valid, res_data}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'(1));
    mon_en = 1;

    opa[0] = 1; opa[1] = 2; opa[2] = 3;
    run_tile(1'b0, 3, 16'd2, 0, 0, got, lat);
    chk("ws_basic_value", 64'(got), 64'(12));
    chk("ws_basic_latency", 64'(lat), 64'(7));

    opa[0] = 3; opa[1] = 4; opb[0] = 5; opb[1] = 6;
    run_tile(1'b1, 2, 16'd9, 0, 0, got, lat);
    chk("os_basic_value", 64'(got), 64'(39));
    chk("os_basic_latency", 64'(lat), 64'(7));

    run_tile(1'b0, 0, 16'd7, 0, 0, got, lat);
    chk("ws_k0_value", 64'(got), 64'(0));
    chk("ws_k0_latency", 64'(lat), 64'(2));
    run_tile(1'b1, 0, 16'd7, 0, 1, got, lat);
    chk("os_k0_value", 64'(got), 64'(0));

    for (int i = 0; i < 4; i++) begin opa[i] = DW'($urandom); opb[i] = DW'($urandom); end
    run_tile(1'b0, 4, DW'($urandom), 1, 5, got, lat);
    run_tile(1'b1, 4, DW'($urandom), 1, 5, got, lat);

    opa[0] = 1; opa[1] = 1;
    run_tile(1'b0, 2, 16'd3, 0, 0, got, lat);
    chk("b2b_ws_value", 64'(got), 64'(6));
    for (int i = 0; i < 3; i++) begin opa[i] = DW'($urandom); opb[i] = DW'($urandom); end
    run_tile(1'b1, 3, 16'd0, 0, 0, got, lat);

    repeat (25) begin
      int k;
      k = $urandom_range(0, 12);
      for (int i = 0; i < k; i++) begin opa[i] = DW'($urandom); opb[i] = DW'($urandom); end
      run_tile(1'($urandom), k, DW'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), got, lat);
    end

    // reset in the middle of a WS stream
    mon_en = 0;
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_k = 8'd8; cmd_w = 16'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    op_valid = 1'b1; op_a = 16'd9;
    repeat (4) @(negedge clk);
    chk("mid_stream_busy", 64'({busy, op_ready}), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'({cmd_ready, op_ready, busy}), 64'(0));
    chk("mid_rst_pe", 64'({pe_mode, pe_load_w, pe_clr, pe_valid, pe_w, pe_a, pe_b}), 64'(0));
    chk("mid_rst_res", 64'({res_valid, res_data}), 64'(0));
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", 64'(cmd_ready), 64'(1));
    exp_beats.delete();
    cur_mode = 0;
    mon_en = 1;
    opa[0] = 5;
    run_tile(1'b0, 1, 16'd5, 0, 0, got, lat);
    chk("post_rst_value", 64'(got), 64'(25));
`ifdef PE_SEQ_PERF_EN
    chk("perf_tiles", 64'(perf_tiles), 64'(1));
`endif
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe_tile_sequencer.md
# pe_tile_sequencer

Sequencer for one `ws_os_pe` processing element, or a row of PEs that share broadcast controls. It accepts one tile command at a time and runs that tile in either weight-stationary (WS) or output-stationary (OS) mode. For each tile it clears the accumulator, streams K operand beats with valid/ready flow control, drains the MAC pipeline, and returns the accumulated result on a valid/ready output port. It sits between the tile scheduler/operand buffers and the PE array.

## Interface
Parameters:
- `DW`, 16, operand width; results are `2*DW`.
- `KW`, 8, width of the tile length field.
- `PE_LAT`, 1, PE MAC latency in cycles from `pe_valid` to an updated `pe_accum`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  tile command valid.
- `cmd_ready`  out  1  command accepted when both are high.
- `cmd_mode`  in  1  0 = WS, 1 = OS.
- `cmd_k`  in  KW  number of operand beats in the tile.
- `cmd_w`  in  DW  stationary weight (WS only).
- `op_valid`, `op_ready`  in/out  1  operand stream handshake.
- `op_a`, `op_b`  in  DW  operands; `op_b` is ignored in WS.
- `pe_mode`  out  1  PE mode.
- `pe_load_w`  out  1  PE weight-load strobe.
- `pe_w`  out  DW  weight to the PE.
- `pe_clr`  out  1  PE synchronous accumulator clear.
- `pe_valid`  out  1  PE MAC enable.
- `pe_a`, `pe_b`  out  DW  PE operands.
- `pe_accum`  in  2*DW  PE accumulator.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accepted when both are high.
- `res_data`  out  2*DW  tile result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
States:
- **IDLE**
  - `cmd_ready=1`.
  - On a command handshake: latch mode, k and w; drive `pe_mode=cmd_mode`; go to LOAD.
- **LOAD** (1 cycle)
  - Drive `pe_clr=1`.
  - WS also drives `pe_load_w=1` and `pe_w=w`.
  - Go to STREAM; go to RESULT instead if k=0.
- **STREAM**
  - `op_ready=1` while the beat count is below k.
  - Each handshake increments the count and registers one PE beat.
  - WS beat: `pe_a=op_a`, `pe_b=0`.
  - OS beat: `pe_a=a_d`, `pe_b=op_b`.
    - `a_d` is the previously accepted `op_a`; it is 0 on the first beat of the tile.
    - This compensates for the PE using the b value from the prior beat.
  - After beat k: WS goes to DRAIN, OS goes to FLUSH.
- **FLUSH** (OS only, 1 cycle)
  - Issue one PE beat with `pe_a=a_d` (the last a) and `pe_b=0`.
  - Go to DRAIN.
- **DRAIN**
  - Wait PE_LAT+1 cycles with `pe_valid=0`.
  - Capture `pe_accum` into `res_data`.
  - Go to RESULT.
- **RESULT**
  - `res_valid=1`; `res_data` is held stable until `res_ready`.
  - On handshake, go to IDLE.
  - For k=0, `res_data=0`; the PE value is not sampled.

Rules:
- `pe_mode` holds its last tile's value in IDLE.
- `pe_w` holds its last value.
- `pe_a` and `pe_b` are 0 whenever `pe_valid=0`.
- The result is the PE's modular `2*DW` accumulation; the sequencer performs no saturation.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd_ready=0` in the cycle of reset, then 1 once in IDLE.
  - `op_ready`, `pe_*`, `res_valid`, `res_data`, `busy` = 0.
- Control strobes:
  - `pe_valid` rises the cycle after the operand handshake.
  - `pe_load_w` and `pe_clr` are single-cycle pulses.
- Tile latency with no stalls, counted from command accept:
  - WS: k+3+PE_LAT cycles to `res_valid`.
  - OS: k+4+PE_LAT cycles.
- Boundary behaviour:
  - `op_valid` low in STREAM: no PE beat, count unchanged.
  - `res_ready` low: stay in RESULT.
  - A new command is never accepted while busy.
- Reset asserted mid-tile: immediately return to IDLE with all outputs at reset values. The PE is cleared at the next LOAD.

## Configuration
- `PE_SEQ_PERF_EN` defined:
  - Adds `perf_tiles` (32) and `perf_stall` (32) outputs.
  - `perf_tiles` counts result handshakes.
  - `perf_stall` counts STREAM cycles with `op_ready` high and `op_valid` low, plus RESULT cycles with `res_ready` low.
  - Both counters wrap and reset to 0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- **WS basic:** k=3, w=2, a=1,2,3 with no gaps.
  - Expect `res_data=12`, `res_valid` at cycle 7 after accept (PE_LAT=1).
  - Expect exactly one `pe_load_w`/`pe_clr` pulse.
- **OS basic:** k=2, a=(3,4), b=(5,6).
  - Expect `res_data=39`.
  - PE sees beats (a,b) = (0,5), (3,6), (4,0).
- **k=0, either mode:** `res_data=0`, no `pe_valid` pulse, `res_valid` two cycles after accept.
- **Backpressure:** `op_valid` toggles every other cycle and `res_ready` is held low for 5 cycles.
  - Result is still correct and stable while held.
  - `cmd_ready=0` until the result handshake.
- **Back-to-back tiles:** WS (w=3, a=1,1 → 6) followed by OS.
  - The second result is unaffected by the first.
- **Reset mid-STREAM:** all outputs return to 0 and the next WS tile (k=1, w=5, a=5) returns 25.
  - With `PE_SEQ_PERF_EN` defined, `perf_tiles=1` afterwards.
